gb80_fetch: RTL and testbench
=============================

Name: gb80_fetch

Overview:
- Instruction fetch stage of the GB80 core. Sits directly upstream of the decoder.
- Owns the program counter and reads opcode and operand bytes over the 8-bit memory bus.
- Determines instruction length from the opcode and delivers a complete instruction bundle to the decoder over a valid/ready handshake.
- The execute stage redirects it through a flush port on jumps, calls, returns and interrupts.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_rd_o  out  1  read request; held with mem_addr_o until acked or withdrawn.
- mem_addr_o  out  16  byte address of the current request.
- mem_ack_i  in  1  one-cycle pulse; mem_rdata_i is valid in the same cycle.
- mem_rdata_i  in  8  read data.
- ins_valid_o  out  1  instruction bundle valid.
- ins_ready_i  in  1  decoder accepts the bundle.
- ins_opcode_o  out  8  opcode byte; for CB-prefixed instructions, the byte after 0xCB.
- ins_cb_o  out  1  1 = CB-prefixed instruction.
- ins_imm_o  out  16  immediate; byte1 in [7:0], byte2 in [15:8]; unused bytes are 0.
- ins_len_o  out  2  total length in bytes (1..3), CB prefix included.
- ins_pc_o  out  16  address of the first byte of the instruction.
- flush_i  in  1  redirect request.
- flush_pc_i  in  16  new PC for the redirect.

Behaviour:
- Reset values: pc=RESET_PC, state=FETCH_OP, mem_rd_o=0, mem_addr_o=0, ins_valid_o=0, all ins_* data outputs=0, prefetch buffer invalid.
- FSM states: FETCH_OP, FETCH_B1, FETCH_B2, PRESENT.
- In every FETCH_* state, mem_rd_o=1 and mem_addr_o=pc. Each ack captures mem_rdata_i and increments pc, wrapping modulo 2^16 (0xFFFF -> 0x0000).
- FETCH_OP, on ack:
  - Record ins_pc=pc before the increment.
  - Look up the length: len 2 or 3 -> FETCH_B1; len 1 -> PRESENT.
- Length table:
  - 3 bytes: 01,11,21,31,08,C2,C3,CA,D2,DA,C4,CC,CD,D4,DC,EA,FA.
  - 2 bytes: 06,0E,16,1E,26,2E,36,3E,10,18,20,28,30,38,C6,CE,D6,DE,E6,EE,F6,FE,E0,F0,E8,F8,CB.
  - 1 byte: all other opcodes. Undefined opcodes are treated as len 1 and passed through unchanged.
- 0xCB prefix: FETCH_B1 ack stores the byte as ins_opcode, sets ins_cb=1 and ins_len=2, imm=0, then -> PRESENT.
- FETCH_B1 (non-CB), on ack: imm[7:0]=byte; len 2 -> PRESENT, len 3 -> FETCH_B2.
- FETCH_B2, on ack: imm[15:8]=byte, then -> PRESENT.
- Fetch latency: 1 cycle per byte minimum, plus memory wait states. ins_valid_o asserts the cycle after the final ack.
- PRESENT: ins_valid_o=1 and all ins_* outputs held stable while ins_ready_i=0. Transfer occurs on valid&&ready, then -> FETCH_OP the next cycle, with ins_valid_o=0 in that cycle.
- Request withdrawal: a request may drop without an ack only because of a flush; the memory side must tolerate this.
- Flush (highest priority, any state):
  - Takes effect at the clock edge where flush_i=1: pc<=flush_pc_i, state<=FETCH_OP, ins_valid_o<=0, prefetch buffer invalidated.
  - Any mem_ack_i in the flush cycle is discarded.
  - A bundle presented in the flush cycle is not transferred, even if ins_ready_i=1.
  - mem_rd_o is 0 in the cycle after a flush; the fetch from the new PC starts the following cycle.
- Asynchronous reset mid-instruction returns immediately to the reset values; no partial bundle survives.

Optional Feature:
- PREFETCH_EN defined:
  - In PRESENT, the unit keeps reading the next opcode (mem_addr_o=pc) into a 1-byte prefetch buffer. It holds at most one byte; mem_rd_o drops once the buffer is full.
  - After a transfer, if the buffer is valid, the opcode phase completes from the buffer in zero memory cycles: the next state is decided from the buffered byte in the transfer cycle itself.
  - Back-to-back 1-byte instructions therefore sustain one bundle every 2 cycles with zero-wait memory.
  - Flush invalidates the buffer.
- PREFETCH_EN undefined: mem_rd_o=0 in PRESENT and no buffer exists.

Test Plan:
- Reset with RESET_PC=0x0100, memory {0x00}, ready=1, zero-wait memory -> mem_addr_o=0x0100; bundle opcode=00, len=1, pc=0x0100; next request at 0x0101.
- Bytes C3 50 01 at 0x0100 -> one bundle: opcode=C3, imm=0x0150, len=3, cb=0, pc=0x0100.
- Bytes CB 37 -> opcode=37, cb=1, len=2, imm=0; next fetch address = pc+2.
- ins_ready_i=0 for 5 cycles while a 3E 42 bundle is presented -> all outputs stable; exactly one transfer when ready rises.
- flush_i with flush_pc_i=0x0038 asserted while waiting for an ack in FETCH_B2, with an ack arriving in the same cycle -> that byte is discarded, no bundle is emitted, and the next request is at 0x0038.
- PC=0xFFFF with opcode 01 and 2 operand bytes -> operands read from 0x0000 and 0x0001; ins_pc=0xFFFF.

Source files
------------

// File: rtl/gb80_fetch.sv
// GB80 instruction fetch stage: owns the PC, reads opcode/operand bytes, presents decoded-length bundles.
// Optional build macro PREFETCH_EN adds a one-byte opcode prefetch buffer that fills while a bundle waits.
module gb80_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_rd_o,
    output logic [15:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [7:0]  mem_rdata_i,
    output logic        ins_valid_o,
    input  logic        ins_ready_i,
    output logic [7:0]  ins_opcode_o,
    output logic        ins_cb_o,
    output logic [15:0] ins_imm_o,
    output logic [1:0]  ins_len_o,
    output logic [15:0] ins_pc_o,
    input  logic        flush_i,
    input  logic [15:0] flush_pc_i
);
    typedef enum logic [1:0] {FETCH_OP, FETCH_B1, FETCH_B2, PRESENT} state_t;

    state_t      state, state_d;
    logic [15:0] pc, pc_d;
    logic        idle, idle_d;
    logic        ins_valid_d, ins_cb_d;
    logic [7:0]  ins_opcode_d;
    logic [15:0] ins_imm_d, ins_pc_d;
    logic [1:0]  ins_len_d;
    logic        ack, xfer, take_op;
    logic [7:0]  op_byte;
    logic [15:0] op_pc;
`ifdef PREFETCH_EN
    logic        pf_valid, pf_valid_d;
    logic [7:0]  pf_data, pf_data_d;
`endif

    function automatic logic [1:0] op_len(input logic [7:0] op);
        case (op)
            8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hC2, 8'hC3, 8'hCA, 8'hD2,
            8'hDA, 8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC, 8'hEA, 8'hFA:
                op_len = 2'd3;
            8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h10,
            8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'hC6, 8'hCE, 8'hD6, 8'hDE,
            8'hE6, 8'hEE, 8'hF6, 8'hFE, 8'hE0, 8'hF0, 8'hE8, 8'hF8, 8'hCB:
                op_len = 2'd2;
            default:
                op_len = 2'd1;
        endcase
    endfunction

    // idle marks the dead cycle that follows reset and every flush.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves the signal unassigned (latch).
        mem_rd_o = 1'b0;
        if (!idle) begin
            if (state != PRESENT) mem_rd_o = 1'b1;
`ifdef PREFETCH_EN
            else mem_rd_o = !pf_valid;
`endif
        end
    end

    assign mem_addr_o = mem_rd_o ? pc : 16'h0000;
    assign ack        = mem_ack_i && mem_rd_o && !flush_i;
    assign xfer       = ins_valid_o && ins_ready_i && !flush_i;

    always_comb begin
        state_d      = state;
        pc_d         = pc;
        idle_d       = 1'b0;
        ins_opcode_d = ins_opcode_o;
        ins_cb_d     = ins_cb_o;
        ins_imm_d    = ins_imm_o;
        ins_len_d    = ins_len_o;
        ins_pc_d     = ins_pc_o;
        take_op      = 1'b0;
        op_byte      = mem_rdata_i;
        op_pc        = pc;
`ifdef PREFETCH_EN
        pf_valid_d   = pf_valid;
        pf_data_d    = pf_data;
`endif
        if (ack) pc_d = pc + 16'd1;

        case (state)
            FETCH_OP: take_op = ack;
            FETCH_B1: begin
                if (ack) begin
                    if (ins_opcode_o == 8'hCB) begin
                        ins_opcode_d = mem_rdata_i;
                        ins_cb_d     = 1'b1;
                        state_d      = PRESENT;
                    end else begin
                        ins_imm_d[7:0] = mem_rdata_i;
                        state_d        = (ins_len_o == 2'd2) ? PRESENT : FETCH_B2;
                    end
                end
            end
            FETCH_B2: begin
                if (ack) begin
                    ins_imm_d[15:8] = mem_rdata_i;
                    state_d         = PRESENT;
                end
            end
            PRESENT: begin
                if (xfer) begin
                    state_d = FETCH_OP;
`ifdef PREFETCH_EN
                    // A buffered byte, or one arriving right now, is the next opcode.
                    if (pf_valid) begin
                        take_op    = 1'b1;
                        op_byte    = pf_data;
                        op_pc      = pc - 16'd1;
                        pf_valid_d = 1'b0;
                    end else begin
                        take_op = ack;
                    end
                end else if (ack) begin
                    pf_valid_d = 1'b1;
                    pf_data_d  = mem_rdata_i;
`endif
                end
            end
            default: state_d = FETCH_OP;
        endcase

        if (take_op) begin
            ins_pc_d     = op_pc;
            ins_opcode_d = op_byte;
            ins_cb_d     = 1'b0;
            ins_imm_d    = 16'h0000;
            ins_len_d    = op_len(op_byte);
            state_d      = (op_len(op_byte) == 2'd1) ? PRESENT : FETCH_B1;
        end

        // Valid stays low for one cycle after every transfer, even if the next bundle is ready.
        ins_valid_d = (state_d == PRESENT) && !xfer;

        if (flush_i) begin
            state_d     = FETCH_OP;
            pc_d        = flush_pc_i;
            idle_d      = 1'b1;
            ins_valid_d = 1'b0;
`ifdef PREFETCH_EN
            pf_valid_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FETCH_OP;
            pc           <= RESET_PC;
            idle         <= 1'b1;
            ins_valid_o  <= 1'b0;
            ins_opcode_o <= 8'h00;
            ins_cb_o     <= 1'b0;
            ins_imm_o    <= 16'h0000;
            ins_len_o    <= 2'd0;
            ins_pc_o     <= 16'h0000;
`ifdef PREFETCH_EN
            pf_valid     <= 1'b0;
            pf_data      <= 8'h00;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state        <= state_d;
            pc           <= pc_d;
            idle         <= idle_d;
            ins_valid_o  <= ins_valid_d;
            ins_opcode_o <= ins_opcode_d;
            ins_cb_o     <= ins_cb_d;
            ins_imm_o    <= ins_imm_d;
            ins_len_o    <= ins_len_d;
            ins_pc_o     <= ins_pc_d;
`ifdef PREFETCH_EN
            pf_valid     <= pf_valid_d;
            pf_data      <= pf_data_d;
`endif
        end
    end
endmodule

// File: tb/tb_gb80_fetch.sv
// Self-checking bench for gb80_fetch: memory responder, expected-bundle scoreboard, flush/reset/wrap cases.
module tb_gb80_fetch;
    logic        clk, rst_n;
    logic        mem_rd_o, mem_ack_i;
    logic [15:0] mem_addr_o;
    logic [7:0]  mem_rdata_i;
    logic        ins_valid_o, ins_ready_i, ins_cb_o;
    logic [7:0]  ins_opcode_o;
    logic [15:0] ins_imm_o, ins_pc_o;
    logic [1:0]  ins_len_o;
    logic        flush_i;
    logic [15:0] flush_pc_i;

    gb80_fetch #(.RESET_PC(16'h0100)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_rd_o     (mem_rd_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .ins_valid_o  (ins_valid_o),
        .ins_ready_i  (ins_ready_i),
        .ins_opcode_o (ins_opcode_o),
        .ins_cb_o     (ins_cb_o),
        .ins_imm_o    (ins_imm_o),
        .ins_len_o    (ins_len_o),
        .ins_pc_o     (ins_pc_o),
        .flush_i      (flush_i),
        .flush_pc_i   (flush_pc_i)
    );

    typedef struct packed {
        logic [7:0]  op;
        logic        cb;
        logic [15:0] imm;
        logic [1:0]  len;
        logic [15:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] ack_log[$];
    logic [7:0]  mem [65536];
    logic        rand_wait;
    logic [15:0] load_pc;
    int          total, bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory responder: acks a request in its first cycle, or randomly later when rand_wait is set.
    always @(negedge clk) begin
        if (mem_rd_o && (!rand_wait || $urandom_range(0, 2) == 0)) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = mem[mem_addr_o];
            ack_log.push_back(mem_addr_o);
        end else begin
            mem_ack_i   = 1'b0;
            mem_rdata_i = 8'h00;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Writes an instruction at load_pc and queues the bundle it must produce.
    task automatic put(input int len, input logic [7:0] b0, input logic [7:0] b1 = 8'h00,
                       input logic [7:0] b2 = 8'h00);
        exp_t        e;
        logic [15:0] a1, a2;
        a1 = load_pc + 16'd1;
        a2 = load_pc + 16'd2;
        mem[load_pc] = b0;
        if (len > 1) mem[a1] = b1;
        if (len > 2) mem[a2] = b2;
        e.pc = load_pc;
        if (b0 == 8'hCB) begin
            e.op = b1; e.cb = 1'b1; e.imm = 16'h0000; e.len = 2'd2;
        end else begin
            e.op  = b0;
            e.cb  = 1'b0;
            e.imm = ((len >= 2) ? {8'h00, b1} : 16'h0000) | ((len == 3) ? {b2, 8'h00} : 16'h0000);
            e.len = 2'(len);
        end
        exp_q.push_back(e);
        load_pc = load_pc + 16'(len);
    endtask

    task automatic cmp_bundle(input exp_t e, input string tag);
        check({tag, "_valid"}, ins_valid_o, 1'b1);
        check({tag, "_opcode"}, ins_opcode_o, e.op);
        check({tag, "_cb"}, ins_cb_o, e.cb);
        check({tag, "_imm"}, ins_imm_o, e.imm);
        check({tag, "_len"}, ins_len_o, e.len);
        check({tag, "_pc"}, ins_pc_o, e.pc);
    endtask

    task automatic take_bundle(input int stall);
        exp_t e;
        int   n;
        n = 0;
        while (!ins_valid_o && n < 200) begin
            step();
            n++;
        end
        check("valid_wait", ins_valid_o, 1'b1);
        check("sb_avail", exp_q.size() > 0, 1'b1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        cmp_bundle(e, "bundle");
        for (int i = 0; i < stall; i++) begin
            step();
            cmp_bundle(e, "hold");
        end
        ins_ready_i = 1'b1;
        step();
        ins_ready_i = 1'b0;
        check("valid_after_xfer", ins_valid_o, 1'b0);
    endtask

    task automatic wait_addr(input logic [15:0] a, input string tag);
        int n;
        n = 0;
        while (!(mem_rd_o && mem_addr_o == a) && n < 200) begin
            step();
            n++;
        end
        check(tag, {mem_rd_o, mem_addr_o}, {1'b1, a});
    endtask

    task automatic do_flush(input logic [15:0] a);
        step();
        flush_i    = 1'b1;
        flush_pc_i = a;
        step();
        flush_i = 1'b0;
        ack_log.delete();
        check("rd_after_flush", mem_rd_o, 1'b0);
        step();
        check("addr_after_flush", {mem_rd_o, mem_addr_o}, {1'b1, a});
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; ins_ready_i = 1'b0; flush_i = 1'b0; flush_pc_i = 16'h0000;
        mem_ack_i = 1'b0; mem_rdata_i = 8'h00; rand_wait = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        // Reset values.
        repeat (3) step();
        check("rst_rd", mem_rd_o, 1'b0);
        check("rst_addr", mem_addr_o, 16'h0000);
        check("rst_valid", ins_valid_o, 1'b0);
        check("rst_opcode", ins_opcode_o, 8'h00);
        check("rst_cb", ins_cb_o, 1'b0);
        check("rst_imm", ins_imm_o, 16'h0000);
        check("rst_len", ins_len_o, 2'd0);
        check("rst_pc", ins_pc_o, 16'h0000);

        // Straight-line fetch: 1-, 3-, CB- and 2-byte instructions, the last one stalled.
        load_pc = 16'h0100;
        put(1, 8'h00);
        put(3, 8'hC3, 8'h50, 8'h01);
        put(2, 8'hCB, 8'h37);
        put(2, 8'h3E, 8'h42);
        rst_n = 1'b1;
        wait_addr(16'h0100, "first_req");
        step();
        check("lat_1byte", ins_valid_o, 1'b1);
        take_bundle(0);
        take_bundle(0);
        take_bundle(0);
        take_bundle(5);
        for (int i = 0; i < 8; i++)
            check("seq_addr", (i < ack_log.size()) ? {16'h0000, ack_log[i]} : 32'hDEAD, 32'h0100 + i);

        // Flush in FETCH_B2 with a coincident ack: the byte is dropped, no 01 bundle appears.
        mem[16'h0200] = 8'h01; mem[16'h0201] = 8'hAA; mem[16'h0202] = 8'hBB;
        load_pc = 16'h0038;
        put(1, 8'h00);
        do_flush(16'h0200);
        wait_addr(16'h0202, "b2_req");
        check("b2_ack", mem_ack_i, 1'b1);
        flush_i    = 1'b1;
        flush_pc_i = 16'h0038;
        step();
        flush_i = 1'b0;
        check("rd_after_b2_flush", mem_rd_o, 1'b0);
        check("valid_after_b2_flush", ins_valid_o, 1'b0);
        step();
        check("addr_after_b2_flush", {mem_rd_o, mem_addr_o}, {1'b1, 16'h0038});
        take_bundle(0);

        // PC wrap across 0xFFFF.
        load_pc = 16'hFFFF;
        put(3, 8'h01, 8'h34, 8'h12);
        do_flush(16'hFFFF);
        take_bundle(0);
        check("wrap_addr0", (ack_log.size() > 0) ? {16'h0000, ack_log[0]} : 32'hDEAD, 32'hFFFF);
        check("wrap_addr1", (ack_log.size() > 1) ? {16'h0000, ack_log[1]} : 32'hDEAD, 32'h0000);
        check("wrap_addr2", (ack_log.size() > 2) ? {16'h0000, ack_log[2]} : 32'hDEAD, 32'h0001);

        // Mixed stream with memory wait states and random decoder stalls.
        load_pc = 16'h0300;
        put(1, 8'h00);
        put(2, 8'h06, 8'h11);
        put(3, 8'h21, 8'h22, 8'h33);
        put(2, 8'hCB, 8'h7C);
        put(1, 8'h3C);
        put(3, 8'hEA, 8'h00, 8'hC0);
        put(2, 8'h18, 8'hFE);
        put(1, 8'h76);
        rand_wait = 1'b1;
        do_flush(16'h0300);
        for (int i = 0; i < 8; i++) take_bundle(int'($urandom_range(0, 3)));
        rand_wait = 1'b0;

        // Asynchronous reset in the middle of an instruction.
        do_flush(16'h0200);
        wait_addr(16'h0201, "b1_req");
        rst_n = 1'b0;
        #1;
        check("mid_rst_rd", mem_rd_o, 1'b0);
        check("mid_rst_addr", mem_addr_o, 16'h0000);
        check("mid_rst_valid", ins_valid_o, 1'b0);
        check("mid_rst_opcode", ins_opcode_o, 8'h00);
        check("mid_rst_len", ins_len_o, 2'd0);
        check("mid_rst_pc", ins_pc_o, 16'h0000);
        step();
        rst_n = 1'b1;
        load_pc = 16'h0100;
        put(1, 8'h00);
        wait_addr(16'h0100, "req_after_rst");
        take_bundle(0);

        check("sb_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
